// File: rtl/mem_port_arb.sv
// mem_port_arb: two-requester round-robin arbiter in front of one RAM port.
// Reads return one cycle after accept; the response is steered into a
// 2-entry FIFO owned by the requester that issued it. Read requests are
// gated by a credit, so a FIFO can never be overrun.
// Optional build macro MEM_PORT_ARB_CHECK_EN adds a sticky err_o output and
// simulation assertions on orphan responses, FIFO overflow and dropped
// request valids.

// Per-requester response path: 2-entry FIFO plus read-credit computation.
module mem_port_arb_lane (
  input  logic        clk,
  input  logic        rstf,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        inflight_mine,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        credit,
  output logic        ovf
);
  logic [1:0][31:0] mem;
  logic             wptr;
  logic             rptr;
  logic [1:0]       occ;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [2:0]       owed;

  assign rsp_valid = (occ != 2'd0);
  assign rsp_data  = mem[rptr];
  assign pop       = rsp_valid & rsp_ready;
  assign full      = (occ == 2'd2);
  // A push into a full FIFO that is not popping the same cycle is an overflow;
  // it is dropped rather than corrupting the head entry.
  assign ovf       = push & full & ~pop;
  assign push_ok   = push & ~ovf;
  // Slots already promised: stored entries plus the read whose data lands at
  // the end of this cycle, less the entry leaving this cycle.
  assign owed      = {1'b0, occ} + {2'b00, inflight_mine} - {2'b00, pop};
  assign credit    = (owed < 3'd2);

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      mem  <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      if (push_ok && !pop)      occ <= occ + 2'd1;
      else if (!push_ok && pop) occ <= occ - 2'd1;
    end
  end
endmodule

module mem_port_arb #(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rstf,
  input  logic              t_r0_valid,
  output logic              t_r0_ready,
  input  logic              t_r0_we,
  input  logic [ADDR_W-1:0] t_r0_addr,
  input  logic [31:0]       t_r0_data,
  input  logic [3:0]        t_r0_mask,
  input  logic              t_r1_valid,
  output logic              t_r1_ready,
  input  logic              t_r1_we,
  input  logic [ADDR_W-1:0] t_r1_addr,
  input  logic [31:0]       t_r1_data,
  input  logic [3:0]        t_r1_mask,
  output logic              i_r0_valid,
  input  logic              i_r0_ready,
  output logic [31:0]       i_r0_data,
  output logic              i_r1_valid,
  input  logic              i_r1_ready,
  output logic [31:0]       i_r1_data,
  output logic              i_m_valid,
  input  logic              t_m_ready,
  output logic              i_m_we,
  output logic [ADDR_W-1:0] i_m_addr,
  output logic [31:0]       i_m_data,
  output logic [3:0]        i_m_mask,
  input  logic              t_m_rsp_valid,
  input  logic [31:0]       t_m_rsp_data
`ifdef MEM_PORT_ARB_CHECK_EN
  ,
  output logic              err_o
`endif
);
  localparam int NREQ = 2;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_we;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][31:0]       req_data;
  logic [NREQ-1:0][3:0]        req_mask;
  logic [NREQ-1:0]             rsp_valid;
  logic [NREQ-1:0]             rsp_ready;
  logic [NREQ-1:0][31:0]       rsp_data;
  logic [NREQ-1:0]             credit;
  logic [NREQ-1:0]             ovf;
  logic [NREQ-1:0]             elig;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             mine;
  logic [NREQ-1:0]             push;

  // prio names the requester that wins a tie; it is the one not granted last.
  logic prio;
  logic inflight;
  logic inflight_id;
  logic gnt_id;
  logic accept;

  assign req_valid = {t_r1_valid, t_r0_valid};
  assign req_we    = {t_r1_we, t_r0_we};
  assign req_addr  = {t_r1_addr, t_r0_addr};
  assign req_data  = {t_r1_data, t_r0_data};
  assign req_mask  = {t_r1_mask, t_r0_mask};
  assign rsp_ready = {i_r1_ready, i_r0_ready};

  assign i_r0_valid = rsp_valid[0];
  assign i_r1_valid = rsp_valid[1];
  assign i_r0_data  = rsp_data[0];
  assign i_r1_data  = rsp_data[1];

  // Writes never wait for response space; reads need a credit.
  assign elig = req_valid & (req_we | credit);

  // Round-robin pick among eligible requesters.
  always_comb begin
    gnt_id = 1'b0;
    if (elig == 2'b11) gnt_id = prio;
    else if (elig[1])  gnt_id = 1'b1;
  end

  assign gnt       = (elig == 2'b00) ? 2'b00 : (gnt_id ? 2'b10 : 2'b01);
  assign req_ready = gnt & {NREQ{t_m_ready}};
  assign t_r0_ready = req_ready[0];
  assign t_r1_ready = req_ready[1];

  assign i_m_valid = |elig;
  assign i_m_we    = req_we[gnt_id];
  assign i_m_addr  = req_addr[gnt_id];
  assign i_m_data  = req_data[gnt_id];
  assign i_m_mask  = req_mask[gnt_id];
  assign accept    = i_m_valid & t_m_ready;

  // Returning RAM data belongs to whoever issued last cycle's read.
  assign mine = inflight ? (inflight_id ? 2'b10 : 2'b01) : 2'b00;
  assign push = mine & {NREQ{t_m_rsp_valid}};

  // Arbitration pointer and single outstanding-read tracker.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      prio        <= 1'b0;
      inflight    <= 1'b0;
      inflight_id <= 1'b0;
    end else begin
      inflight <= accept & ~i_m_we;
      if (accept) prio <= ~gnt_id;
      if (accept && !i_m_we) inflight_id <= gnt_id;
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    mem_port_arb_lane u_lane (
      .clk          (clk),
      .rstf         (rstf),
      .push         (push[i]),
      .push_data    (t_m_rsp_data),
      .inflight_mine(mine[i]),
      .rsp_ready    (rsp_ready[i]),
      .rsp_valid    (rsp_valid[i]),
      .rsp_data     (rsp_data[i]),
      .credit       (credit[i]),
      .ovf          (ovf[i])
    );
  end

`ifdef MEM_PORT_ARB_CHECK_EN
  // Sticky error: orphan RAM response or a push into a full FIFO.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) err_o <= 1'b0;
    else if ((t_m_rsp_valid && !inflight) || (ovf != 2'b00)) err_o <= 1'b1;
  end

  a_orphan_rsp: assert property (@(posedge clk) disable iff (!rstf)
    t_m_rsp_valid |-> inflight);
  a_fifo_ovf: assert property (@(posedge clk) disable iff (!rstf)
    ovf == 2'b00);
  for (genvar i = 0; i < NREQ; i++) begin : g_hold
    a_valid_hold: assert property (@(posedge clk) disable iff (!rstf)
      (req_valid[i] && gnt[i] && !req_ready[i]) |=> req_valid[i]);
  end
`else
  logic unused_ovf;
  assign unused_ovf = |ovf;
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// Randomised bench for mem_port_arb. A behavioural RAM answers the DUT's
// port; a reference model predicts grants, ready, response timing and data
// from queues of outstanding reads per requester.
module tb_mem_port_arb;
  localparam int DEPTH = 8192;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic          clk = 1'b0;
  logic          rstf;
  logic          t_r0_valid, t_r0_ready, t_r0_we;
  logic [AW-1:0] t_r0_addr;
  logic [31:0]   t_r0_data;
  logic [3:0]    t_r0_mask;
  logic          t_r1_valid, t_r1_ready, t_r1_we;
  logic [AW-1:0] t_r1_addr;
  logic [31:0]   t_r1_data;
  logic [3:0]    t_r1_mask;
  logic          i_r0_valid, i_r0_ready;
  logic [31:0]   i_r0_data;
  logic          i_r1_valid, i_r1_ready;
  logic [31:0]   i_r1_data;
  logic          i_m_valid, t_m_ready, i_m_we;
  logic [AW-1:0] i_m_addr;
  logic [31:0]   i_m_data;
  logic [3:0]    i_m_mask;
  logic          t_m_rsp_valid;
  logic [31:0]   t_m_rsp_data;

  mem_port_arb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstf(rstf),
    .t_r0_valid(t_r0_valid), .t_r0_ready(t_r0_ready), .t_r0_we(t_r0_we),
    .t_r0_addr(t_r0_addr), .t_r0_data(t_r0_data), .t_r0_mask(t_r0_mask),
    .t_r1_valid(t_r1_valid), .t_r1_ready(t_r1_ready), .t_r1_we(t_r1_we),
    .t_r1_addr(t_r1_addr), .t_r1_data(t_r1_data), .t_r1_mask(t_r1_mask),
    .i_r0_valid(i_r0_valid), .i_r0_ready(i_r0_ready), .i_r0_data(i_r0_data),
    .i_r1_valid(i_r1_valid), .i_r1_ready(i_r1_ready), .i_r1_data(i_r1_data),
    .i_m_valid(i_m_valid), .t_m_ready(t_m_ready), .i_m_we(i_m_we),
    .i_m_addr(i_m_addr), .i_m_data(i_m_data), .i_m_mask(i_m_mask),
    .t_m_rsp_valid(t_m_rsp_valid), .t_m_rsp_data(t_m_rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- behavioural RAM (environment) ----------------
  logic [31:0] ram [64];
  logic        ram_rd = 1'b0;
  logic [31:0] ram_q = '0;

  always @(negedge clk) begin
    logic [31:0] w;
    ram_rd = 1'b0;
    if (i_m_valid && t_m_ready) begin
      if (i_m_we) begin
        w = ram[i_m_addr[7:2]];
        for (int b = 0; b < 4; b++) if (i_m_mask[b]) w[b*8 +: 8] = i_m_data[b*8 +: 8];
        ram[i_m_addr[7:2]] = w;
      end else begin
        ram_rd = 1'b1;
        ram_q  = ram[i_m_addr[7:2]];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    t_m_rsp_valid = ram_rd;
    t_m_rsp_data  = ram_rd ? ram_q : $urandom;
  end

  // ---------------- reference model ----------------
  typedef struct { int c; logic [31:0] d; } exp_t;
  exp_t        sbq [2][$];
  logic [31:0] mdl_mem [64];
  logic        mon_en = 1'b0;
  logic        last_w = 1'b1;
  logic [1:0]  acc_q = 2'b00;
  int          acc_cnt [2] = '{0, 0};
  int          gnt_log [$];

  logic [1:0]    m_v, m_we, m_rr, m_rv, m_pop, m_cred, m_el, m_acc;
  logic [AW-1:0] m_a [2];
  logic [31:0]   m_d [2];
  logic [3:0]    m_m [2];
  logic [31:0]   m_w32;
  logic          m_w, m_mv;
  logic [5:0]    m_idx;

  always @(negedge clk) begin
    m_acc = {t_r1_valid & t_r1_ready, t_r0_valid & t_r0_ready};
    acc_q = m_acc;
    for (int n = 0; n < 2; n++) if (m_acc[n]) acc_cnt[n]++;
    if (m_acc != 2'b00) gnt_log.push_back(int'(m_acc[1]));
    if (mon_en) begin
      m_v  = {t_r1_valid, t_r0_valid};
      m_we = {t_r1_we, t_r0_we};
      m_rr = {i_r1_ready, i_r0_ready};
      m_a[0] = t_r0_addr; m_a[1] = t_r1_addr;
      m_d[0] = t_r0_data; m_d[1] = t_r1_data;
      m_m[0] = t_r0_mask; m_m[1] = t_r1_mask;
      for (int n = 0; n < 2; n++) begin
        m_rv[n]   = (sbq[n].size() > 0) && (sbq[n][0].c + 2 <= cyc);
        m_pop[n]  = m_rv[n] & m_rr[n];
        m_cred[n] = (sbq[n].size() - int'(m_pop[n])) < 2;
        m_el[n]   = m_v[n] & (m_we[n] | m_cred[n]);
      end
      chk("r0_rsp_valid", i_r0_valid, m_rv[0]);
      chk("r1_rsp_valid", i_r1_valid, m_rv[1]);
      if (m_rv[0]) chk("r0_rsp_data", i_r0_data, sbq[0][0].d);
      if (m_rv[1]) chk("r1_rsp_data", i_r1_data, sbq[1][0].d);
      m_w  = (m_el == 2'b11) ? ~last_w : m_el[1];
      m_mv = |m_el;
      chk("m_valid", i_m_valid, m_mv);
      chk("r0_ready", t_r0_ready, m_mv & ~m_w & t_m_ready);
      chk("r1_ready", t_r1_ready, m_mv & m_w & t_m_ready);
      if (m_mv) begin
        chk("m_we", i_m_we, m_we[m_w]);
        chk("m_addr", i_m_addr, m_a[m_w]);
        chk("m_data", i_m_data, m_d[m_w]);
        chk("m_mask", i_m_mask, m_m[m_w]);
      end
      for (int n = 0; n < 2; n++) if (m_pop[n]) void'(sbq[n].pop_front());
      if (m_mv && t_m_ready) begin
        last_w = m_w;
        m_idx  = m_a[m_w][7:2];
        if (m_we[m_w]) begin
          m_w32 = mdl_mem[m_idx];
          for (int b = 0; b < 4; b++) if (m_m[m_w][b]) m_w32[b*8 +: 8] = m_d[m_w][b*8 +: 8];
          mdl_mem[m_idx] = m_w32;
        end else begin
          sbq[m_w].push_back('{c: cyc, d: mdl_mem[m_idx]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0]    wv = '0, wwe = '0, wrr = '0;
  logic          wmr = 1'b1;
  logic          hold_en = 1'b0;
  logic [AW-1:0] wa [2];
  logic [31:0]   wd [2];
  logic [3:0]    wm [2];

  function automatic logic [AW-1:0] baddr(input int word);
    return AW'(word * 4);
  endfunction

  task automatic set_idle();
    wv = 2'b00; wwe = 2'b00;
    for (int n = 0; n < 2; n++) begin wa[n] = '0; wd[n] = '0; wm[n] = '0; end
  endtask

  // Advance one cycle and present the wanted inputs; an un-accepted request
  // is held unchanged when hold_en is set.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!(hold_en && t_r0_valid && !acc_q[0])) begin
      t_r0_valid = wv[0]; t_r0_we = wwe[0]; t_r0_addr = wa[0];
      t_r0_data = wd[0]; t_r0_mask = wm[0];
    end
    if (!(hold_en && t_r1_valid && !acc_q[1])) begin
      t_r1_valid = wv[1]; t_r1_we = wwe[1]; t_r1_addr = wa[1];
      t_r1_data = wd[1]; t_r1_mask = wm[1];
    end
    i_r0_ready = wrr[0];
    i_r1_ready = wrr[1];
    t_m_ready  = wmr;
  endtask

  task automatic rand_cycles(input int n_cyc);
    hold_en = 1'b1;
    for (int k = 0; k < n_cyc; k++) begin
      for (int n = 0; n < 2; n++) begin
        wv[n]  = ($urandom % 10) < 6;
        wwe[n] = ($urandom % 10) < 3;
        wa[n]  = AW'($urandom);
        wd[n]  = $urandom;
        wm[n]  = 4'($urandom);
        wrr[n] = ($urandom % 4) != 0;
      end
      wmr = ($urandom % 10) != 0;
      tick();
    end
    hold_en = 1'b0;
    set_idle(); wrr = 2'b11; wmr = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int c0, c1;

  initial begin
    rstf = 1'b1;
    set_idle();
    t_r0_valid = 0; t_r0_we = 0; t_r0_addr = '0; t_r0_data = '0; t_r0_mask = '0;
    t_r1_valid = 0; t_r1_we = 0; t_r1_addr = '0; t_r1_data = '0; t_r1_mask = '0;
    i_r0_ready = 0; i_r1_ready = 0; t_m_ready = 1;
    t_m_rsp_valid = 0; t_m_rsp_data = '0;
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[4] = 32'hDEADBEEF;
    for (int i = 0; i < 64; i++) mdl_mem[i] = ram[i];
    #1 rstf = 1'b0;
    #2;
    chk("rst_r0_valid", i_r0_valid, 0);
    chk("rst_r1_valid", i_r1_valid, 0);
    chk("rst_r0_data", i_r0_data, 0);
    chk("rst_r1_data", i_r1_data, 0);
    chk("rst_m_valid", i_m_valid, 0);
    chk("rst_r0_ready", t_r0_ready, 0);
    chk("rst_r1_ready", t_r1_ready, 0);
    #10 rstf = 1'b1;
    mon_en = 1'b1;

    // Contention: both read every cycle; grants alternate starting with r0.
    wrr = 2'b11;
    for (int k = 0; k < 8; k++) begin
      wv = 2'b11; wwe = 2'b00;
      wa[0] = baddr(k); wa[1] = baddr(32 + k);
      tick();
    end
    set_idle(); tick();
    chk("contention_grants", gnt_log.size(), 8);
    for (int k = 0; k < 8 && k < gnt_log.size(); k++) chk("contention_order", gnt_log[k], k % 2);
    repeat (4) tick();

    // Single read of 0x10 by r0.
    wv[0] = 1'b1; wa[0] = 'h10;
    tick();
    set_idle();
    repeat (5) tick();

    // Backpressure on r1: only two reads get in, r0 keeps flowing.
    c0 = acc_cnt[0]; c1 = acc_cnt[1];
    wrr = 2'b01;
    for (int k = 0; k < 6; k++) begin
      wv = 2'b11; wwe = 2'b00;
      wa[0] = baddr(8 + k); wa[1] = baddr(40 + k);
      tick();
    end
    // Write from r1 while its FIFO is full.
    set_idle();
    wv[1] = 1'b1; wwe[1] = 1'b1; wa[1] = baddr(9); wd[1] = 32'h11223344; wm[1] = 4'b0101;
    tick();
    chk("bp_r1_reads", acc_cnt[1] - c1, 2);
    chk("bp_r0_reads", acc_cnt[0] - c0, 4);
    set_idle(); tick();
    chk("bp_r1_write", acc_cnt[1] - c1, 3);
    wrr = 2'b11;
    repeat (4) tick();
    c1 = acc_cnt[1];
    for (int k = 0; k < 2; k++) begin wv[1] = 1'b1; wa[1] = baddr(9 + k); tick(); end
    set_idle(); tick();
    chk("bp_resume_reads", acc_cnt[1] - c1, 2);
    repeat (4) tick();

    // Streaming: 8 back-to-back reads from r0, no bubble.
    c0 = acc_cnt[0];
    for (int k = 0; k < 8; k++) begin wv[0] = 1'b1; wa[0] = baddr(16 + k); tick(); end
    set_idle(); tick();
    chk("stream_reads", acc_cnt[0] - c0, 8);
    repeat (4) tick();

    rand_cycles(3000);

    // Async reset between accept and RAM response.
    mon_en = 1'b0;
    wv[0] = 1'b1; wa[0] = baddr(5);
    tick();
    @(negedge clk);
    chk("rst_mid_accept", t_r0_ready, 1);
    set_idle();
    tick();
    #1 rstf = 1'b0;
    #1;
    chk("rst_mid_r0_valid", i_r0_valid, 0);
    chk("rst_mid_r0_data", i_r0_data, 0);
    chk("rst_mid_r1_valid", i_r1_valid, 0);
    @(negedge clk);
    #2 rstf = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_late_r0_valid", i_r0_valid, 0);
      chk("rst_late_r1_valid", i_r1_valid, 0);
    end
    for (int n = 0; n < 2; n++) sbq[n].delete();
    last_w = 1'b1;
    tick();
    mon_en = 1'b1;
    rand_cycles(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
